vga_scan_ctrl: RTL

- Scan and pattern sequencer for the 640x480@60 test display.
- Drives the free-running hc/vc raster counters that feed the colour-bar pattern generator.
- Produces hsync, vsync and active-video.
- Selects which test pattern is shown; pattern changes are applied only at a frame boundary so the display never tears.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_counter.sv | 75 +++++++
 rtl/vga_scan_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults and pattern-sequencer types for the 640x480@60 test display.
package vga_pkg;

  localparam int unsigned VGA_HTOTAL  = 800;
  localparam int unsigned VGA_VTOTAL  = 521;
  localparam int unsigned VGA_HPULSE  = 96;
  localparam int unsigned VGA_VPULSE  = 2;
  localparam int unsigned VGA_HBP     = 144;
  localparam int unsigned VGA_HFP     = 784;
  localparam int unsigned VGA_VBP     = 31;
  localparam int unsigned VGA_VFP     = 511;

  localparam int unsigned VGA_NUM_PATTERNS       = 4;
  localparam int unsigned VGA_PSEL_W             = 2;
  localparam int unsigned VGA_FRAMES_PER_PATTERN = 120;

  // STEADY: no advance outstanding; PENDING: one advance waits for the next frame boundary.
  typedef enum logic {
    STEADY  = 1'b0,
    PENDING = 1'b1
  } pat_state_e;

endpackage

// File: rtl/vga_counter.sv
// Raster counters (hc/vc) with registered sync/active decode and frame boundary detection.
module vga_counter
  import vga_pkg::*;
#(
  parameter int unsigned HTOTAL = VGA_HTOTAL,
  parameter int unsigned VTOTAL = VGA_VTOTAL,
  parameter int unsigned HPULSE = VGA_HPULSE,
  parameter int unsigned VPULSE = VGA_VPULSE,
  parameter int unsigned HBP    = VGA_HBP,
  parameter int unsigned HFP    = VGA_HFP,
  parameter int unsigned VBP    = VGA_VBP,
  parameter int unsigned VFP    = VGA_VFP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic       frame_start,
  output logic       frame_step
);

  localparam logic [9:0] H_LAST  = 10'(HTOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(VTOTAL - 1);
  localparam logic [9:0] H_PULSE = 10'(HPULSE);
  localparam logic [9:0] V_PULSE = 10'(VPULSE);
  localparam logic [9:0] H_BP    = 10'(HBP);
  localparam logic [9:0] H_FP    = 10'(HFP);
  localparam logic [9:0] V_BP    = 10'(VBP);
  localparam logic [9:0] V_FP    = 10'(VFP);

  logic [9:0] hc_next;
  logic [9:0] vc_next;
  logic       h_wrap;
  logic       v_last;

  // Next raster position and the step that wraps the frame back to 0/0.
  always_comb begin
    h_wrap     = (hc == H_LAST);
    v_last     = (vc == V_LAST);
    hc_next    = h_wrap ? '0 : hc + 10'd1;
    vc_next    = vc;
    if (h_wrap) begin
      vc_next = v_last ? '0 : vc + 10'd1;
    end
    frame_step = pix_en && h_wrap && v_last;
  end

  // Counters and decode are updated together from the next-count values, so
  // sync/active always describe the hc/vc currently on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc          <= '0;
      vc          <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_step;
      if (pix_en) begin
        hc     <= hc_next;
        vc     <= vc_next;
        hsync  <= !(hc_next < H_PULSE);
        vsync  <= !(vc_next < V_PULSE);
        active <= (hc_next >= H_BP) && (hc_next < H_FP) &&
                  (vc_next >= V_BP) && (vc_next < V_FP);
      end
    end
  end

endmodule

// File: rtl/vga_scan_ctrl.sv
// Scan and pattern sequencer: raster timing plus tear-free pattern selection.
// Optional macro VGA_AUTO_CYCLE_EN: auto-advance the pattern every
// FRAMES_PER_PATTERN frames when no manual advance is pending.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned HTOTAL             = VGA_HTOTAL,
  parameter int unsigned VTOTAL             = VGA_VTOTAL,
  parameter int unsigned HPULSE             = VGA_HPULSE,
  parameter int unsigned VPULSE             = VGA_VPULSE,
  parameter int unsigned HBP                = VGA_HBP,
  parameter int unsigned HFP                = VGA_HFP,
  parameter int unsigned VBP                = VGA_VBP,
  parameter int unsigned VFP                = VGA_VFP,
  parameter int unsigned NUM_PATTERNS       = VGA_NUM_PATTERNS,
  parameter int unsigned PSEL_W             = VGA_PSEL_W,
  parameter int unsigned FRAMES_PER_PATTERN = VGA_FRAMES_PER_PATTERN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic              adv_req,
  output logic              adv_ack,
  output logic [9:0]        hc,
  output logic [9:0]        vc,
  output logic              hsync,
  output logic              vsync,
  output logic              active,
  output logic              frame_start,
  output logic [PSEL_W-1:0] pattern_sel
);

  localparam logic [PSEL_W-1:0] PSEL_LAST = PSEL_W'(NUM_PATTERNS - 1);

  logic              frame_step;
  pat_state_e        state;
  pat_state_e        state_d;
  logic [PSEL_W-1:0] psel_d;
  logic              ack_d;
  logic              bump;

  vga_counter #(
    .HTOTAL (HTOTAL),
    .VTOTAL (VTOTAL),
    .HPULSE (HPULSE),
    .VPULSE (VPULSE),
    .HBP    (HBP),
    .HFP    (HFP),
    .VBP    (VBP),
    .VFP    (VFP)
  ) u_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .hc          (hc),
    .vc          (vc),
    .hsync       (hsync),
    .vsync       (vsync),
    .active      (active),
    .frame_start (frame_start),
    .frame_step  (frame_step)
  );

`ifdef VGA_AUTO_CYCLE_EN
  localparam int unsigned   FC_W    = $clog2(FRAMES_PER_PATTERN + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_PATTERN - 1);
  localparam logic [FC_W-1:0] FC_MAX  = '1;

  logic [FC_W-1:0] fcnt;
  logic [FC_W-1:0] fcnt_d;
`else
  logic unused_fpp;
  assign unused_fpp = (FRAMES_PER_PATTERN != 0);
`endif

  // Pattern FSM next state: advances are only ever applied on the frame-boundary step.
  // A request coinciding with the boundary step is held for the following boundary.
  always_comb begin
    state_d = state;
    psel_d  = pattern_sel;
    ack_d   = 1'b0;
    bump    = 1'b0;
`ifdef VGA_AUTO_CYCLE_EN
    fcnt_d  = fcnt;
`endif
    if (frame_step) begin
      if (state == PENDING) begin
        bump   = 1'b1;
        ack_d  = 1'b1;
`ifdef VGA_AUTO_CYCLE_EN
        fcnt_d = '0;
`endif
      end else begin
`ifdef VGA_AUTO_CYCLE_EN
        if (fcnt == FC_LAST) begin
          bump   = 1'b1;
          fcnt_d = '0;
        end else if (fcnt != FC_MAX) begin
          fcnt_d = fcnt + 1'b1;
        end
`endif
      end
      state_d = adv_req ? PENDING : STEADY;
    end else if (adv_req) begin
      state_d = PENDING;
    end
    if (bump) begin
      psel_d = (pattern_sel == PSEL_LAST) ? '0 : pattern_sel + 1'b1;
    end
  end

  // Pattern FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= STEADY;
      pattern_sel <= '0;
      adv_ack     <= 1'b0;
    end else begin
      state       <= state_d;
      pattern_sel <= psel_d;
      adv_ack     <= ack_d;
    end
  end

`ifdef VGA_AUTO_CYCLE_EN
  // Frames shown since the last pattern change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= '0;
    end else begin
      fcnt <= fcnt_d;
    end
  end
`endif

endmodule
